// File: rtl/chip_result_display.sv
// -----------------------------------------------------------------------------
// chip_result_display
//
// Downstream consumer of a chip-checker test block. Qualifies the checker's
// Done/RSLT verdict, latches it onto LEDs, shows PASS or FAIL on four
// seven-segment digits for a hold period, keeps saturating pass/fail tallies,
// and then raises DISP_RSLT so the checker can return to Halted. Between tests
// the display shows the live trace nibbles (input_o on HEX0, E on HEX1).
//
// Optional feature (macro CHIP_RESULT_COUNT_DISPLAY_EN):
//   defined   - in IDLE, HEX3 shows pass_count[3:0] and HEX2 fail_count[3:0]
//   undefined - HEX3/HEX2 are blank in IDLE
//
// Parameters:
//   HOLD_CYCLES  cycles the verdict stays on the display (>= 1)
//   CNT_W        width of the pass/fail tally counters
//
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   Done, RSLT            checker test-complete flag and verdict (1 = pass)
//   E, input_o            checker trace nibbles shown between tests
//   Continue              user acknowledge (level); rising edge ends hold early
//   Clear_cnt             synchronous clear of both tallies (beats increment)
//   DISP_RSLT             verdict-displayed acknowledge back to the checker
//   LED_PASS, LED_FAIL    latched verdict indicators
//   HEX0..HEX3            active-low digits, bit order gfedcba, HEX0 rightmost
//   pass_count/fail_count saturating tallies
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module chip_result_display #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Done,
  input  logic             RSLT,
  input  logic [3:0]       E,
  input  logic [3:0]       input_o,
  input  logic             Continue,
  input  logic             Clear_cnt,
  output logic             DISP_RSLT,
  output logic             LED_PASS,
  output logic             LED_FAIL,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int unsigned          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Letter glyphs, active-low gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_L     = 7'b1000111;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHOW,
    RELEASE
  } state_t;

  state_t              state, state_nxt;
  logic                cont_q;
  logic                cont_pulse;
  logic                capture;
  logic                rslt_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [3:0][6:0]     hex_nxt;
  logic                disp_nxt;

  // Standard hex font 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign cont_pulse = Continue & ~cont_q;
  // RSLT is sampled one cycle after Done rises; Done must still be high there,
  // otherwise the Done pulse is treated as a glitch.
  assign capture    = (state == ARM) && Done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Done) state_nxt = ARM;
      ARM:     state_nxt = Done ? SHOW : IDLE;
      SHOW:    if ((hold_cnt == '0) || cont_pulse) state_nxt = RELEASE;
      RELEASE: if (!Done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered on the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_nxt = (state_nxt == RELEASE);
    hex_nxt  = {4{SEG_BLANK}};
    case (state)
      SHOW, RELEASE: begin
        hex_nxt = rslt_q ? {SEG_P, SEG_A, SEG_S, SEG_S}
                         : {SEG_F, SEG_A, SEG_I, SEG_L};
      end
      default: begin
        // Trace view; ARM is not yet a qualified verdict so it keeps it too.
        hex_nxt[0] = hex_font(input_o);
        hex_nxt[1] = hex_font(E);
`ifdef CHIP_RESULT_COUNT_DISPLAY_EN
        hex_nxt[3] = hex_font(4'(pass_count));
        hex_nxt[2] = hex_font(4'(fail_count));
`else
        hex_nxt[3] = SEG_BLANK;
        hex_nxt[2] = SEG_BLANK;
`endif
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cont_q     <= 1'b0;
      hold_cnt   <= '0;
      rslt_q     <= 1'b0;
      LED_PASS   <= 1'b0;
      LED_FAIL   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      DISP_RSLT  <= 1'b0;
      HEX0       <= SEG_BLANK;
      HEX1       <= SEG_BLANK;
      HEX2       <= SEG_BLANK;
      HEX3       <= SEG_BLANK;
    end else begin
      cont_q <= Continue;

      if (capture) begin
        hold_cnt <= HOLD_LOAD;
        rslt_q   <= RSLT;
        LED_PASS <= RSLT;
        LED_FAIL <= ~RSLT;
      end else if ((state == SHOW) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      // Clear takes priority over an increment landing on the same edge.
      if (Clear_cnt) begin
        pass_count <= '0;
        fail_count <= '0;
      end else if (capture) begin
        if (RSLT) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
        end else begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
        end
      end

      DISP_RSLT <= disp_nxt;
      HEX0      <= hex_nxt[0];
      HEX1      <= hex_nxt[1];
      HEX2      <= hex_nxt[2];
      HEX3      <= hex_nxt[3];
    end
  end

endmodule

// File: tb/tb_chip_result_display.sv
// -----------------------------------------------------------------------------
// tb_chip_result_display
//
// Two instances: "a" (HOLD_CYCLES=8, CNT_W=2) driven by directed and randomized
// checker handshakes, and "b" (HOLD_CYCLES=1, CNT_W=8) driven by free-running
// random inputs. A behavioural model per instance predicts every output each
// cycle, sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_chip_result_display;

  localparam int HOLD_A = 8;
  localparam int CNT_A  = 2;
  localparam int HOLD_B = 1;
  localparam int CNT_B  = 8;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] G_P = 7'b0001100, G_A = 7'b0001000, G_S = 7'b0010010;
  localparam logic [6:0] G_F = 7'b0001110, G_I = 7'b1111001, G_L = 7'b1000111;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                       7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                       7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a
  logic       done_a, rslt_a, cont_a, clr_a;
  logic [3:0] e_a, io_a;
  logic       disp_a, lp_a, lf_a;
  logic [6:0] h0_a, h1_a, h2_a, h3_a;
  logic [CNT_A-1:0] pc_a, fc_a;
  // instance b
  logic       done_b, rslt_b, cont_b, clr_b;
  logic [3:0] e_b, io_b;
  logic       disp_b, lp_b, lf_b;
  logic [6:0] h0_b, h1_b, h2_b, h3_b;
  logic [CNT_B-1:0] pc_b, fc_b;

  chip_result_display #(.HOLD_CYCLES(HOLD_A), .CNT_W(CNT_A)) dut_a (
    .Clk(clk), .Reset(rst), .Done(done_a), .RSLT(rslt_a), .E(e_a), .input_o(io_a),
    .Continue(cont_a), .Clear_cnt(clr_a), .DISP_RSLT(disp_a), .LED_PASS(lp_a),
    .LED_FAIL(lf_a), .HEX0(h0_a), .HEX1(h1_a), .HEX2(h2_a), .HEX3(h3_a),
    .pass_count(pc_a), .fail_count(fc_a)
  );

  chip_result_display #(.HOLD_CYCLES(HOLD_B), .CNT_W(CNT_B)) dut_b (
    .Clk(clk), .Reset(rst), .Done(done_b), .RSLT(rslt_b), .E(e_b), .input_o(io_b),
    .Continue(cont_b), .Clear_cnt(clr_b), .DISP_RSLT(disp_b), .LED_PASS(lp_b),
    .LED_FAIL(lf_b), .HEX0(h0_b), .HEX1(h1_b), .HEX2(h2_b), .HEX3(h3_b),
    .pass_count(pc_b), .fail_count(fc_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model: tracks the test phase, elapsed show time and tallies.
  // ---------------------------------------------------------------------------
  typedef enum int {P_IDLE, P_ARM, P_SHOW, P_REL} phase_e;

  typedef struct {
    phase_e          ph;
    bit              verdict;
    int              elapsed;
    bit              prev_cont;
    int              npass;
    int              nfail;
    bit              lp;
    bit              lf;
    bit              disp;
    logic [3:0][6:0] hx;
    bit              hx_ok;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.ph = P_IDLE; s.verdict = 0; s.elapsed = 0; s.prev_cont = 0;
    s.npass = 0; s.nfail = 0; s.lp = 0; s.lf = 0; s.disp = 0;
    s.hx = {4{BLANK}}; s.hx_ok = 1;
    return s;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int hold, int cmax, bit done, bit rslt,
                                    bit cont, bit clr, logic [3:0] e, logic [3:0] io);
    mdl_t n;
    bit   pulse;
    n     = s;
    pulse = cont && !s.prev_cont;
    n.prev_cont = cont;
    // Display for a cycle spent arming is not a verdict view; left unchecked.
    n.hx_ok = (s.ph != P_ARM);
    if (s.ph == P_SHOW || s.ph == P_REL) begin
      n.hx = s.verdict ? {G_P, G_A, G_S, G_S} : {G_F, G_A, G_I, G_L};
    end else begin
      n.hx[0] = FONT[io];
      n.hx[1] = FONT[e];
`ifdef CHIP_RESULT_COUNT_DISPLAY_EN
      n.hx[3] = FONT[s.npass % 16];
      n.hx[2] = FONT[s.nfail % 16];
`else
      n.hx[3] = BLANK;
      n.hx[2] = BLANK;
`endif
    end
    case (s.ph)
      P_IDLE: if (done) n.ph = P_ARM;
      P_ARM: begin
        if (done) begin
          n.verdict = rslt;
          n.lp      = rslt;
          n.lf      = !rslt;
          n.elapsed = 0;
          if (rslt) n.npass = (s.npass < cmax) ? s.npass + 1 : cmax;
          else      n.nfail = (s.nfail < cmax) ? s.nfail + 1 : cmax;
          n.ph = P_SHOW;
        end else begin
          n.ph = P_IDLE;
        end
      end
      P_SHOW: begin
        n.elapsed = s.elapsed + 1;
        if (n.elapsed >= hold || pulse) n.ph = P_REL;
      end
      default: if (!done) n.ph = P_IDLE;
    endcase
    if (clr) begin
      n.npass = 0;
      n.nfail = 0;
    end
    n.disp = (n.ph == P_REL);
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp(input string who, input mdl_t s, input logic disp, input logic lp,
                     input logic lf, input logic [6:0] h0, input logic [6:0] h1,
                     input logic [6:0] h2, input logic [6:0] h3,
                     input logic [31:0] pc, input logic [31:0] fc);
    check({who, "_disp"}, 32'(disp), 32'(s.disp));
    check({who, "_led_pass"}, 32'(lp), 32'(s.lp));
    check({who, "_led_fail"}, 32'(lf), 32'(s.lf));
    check({who, "_pass_count"}, pc, s.npass);
    check({who, "_fail_count"}, fc, s.nfail);
    if (s.hx_ok) begin
      check({who, "_hex0"}, 32'(h0), 32'(s.hx[0]));
      check({who, "_hex1"}, 32'(h1), 32'(s.hx[1]));
      check({who, "_hex2"}, 32'(h2), 32'(s.hx[2]));
      check({who, "_hex3"}, 32'(h3), 32'(s.hx[3]));
    end
  endtask

  task automatic cmp_both();
    cmp("a", ma, disp_a, lp_a, lf_a, h0_a, h1_a, h2_a, h3_a, 32'(pc_a), 32'(fc_a));
    cmp("b", mb, disp_b, lp_b, lf_b, h0_b, h1_b, h2_b, h3_b, 32'(pc_b), 32'(fc_b));
  endtask

  // One clock: advance models with the inputs present at the edge, compare,
  // then refresh the free-running random inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, HOLD_A, (1 << CNT_A) - 1, done_a, rslt_a, cont_a, clr_a, e_a, io_a);
      mb = mdl_step(mb, HOLD_B, (1 << CNT_B) - 1, done_b, rslt_b, cont_b, clr_b, e_b, io_b);
    end
    cmp_both();
    e_a    = 4'($urandom);
    io_a   = 4'($urandom);
    e_b    = 4'($urandom);
    io_b   = 4'($urandom);
    done_b = 1'($urandom);
    rslt_b = 1'($urandom);
    cont_b = ($urandom_range(0, 7) == 0);
    clr_b  = ($urandom_range(0, 15) == 0);
  endtask

  // One checker handshake on instance a. cont_at: SHOW cycle at which Continue
  // rises (-1 = never). early_drop: Done falls during SHOW.
  task automatic run_test(input bit verdict, input int cont_at, input bit clr_at_arm,
                          input bit early_drop);
    int n;
    int exp_n;
    done_a = 1'b1;
    rslt_a = 1'($urandom);      // not yet valid; must be ignored
    tick();
    rslt_a = verdict;
    clr_a  = clr_at_arm;
    tick();
    clr_a  = 1'b0;
    rslt_a = 1'($urandom);
    if (clr_at_arm) check("a_clear_on_arm", 32'(pc_a), 0);
    n = 0;
    while (!disp_a && n < 4 * HOLD_A + 8) begin
      if (cont_at >= 0 && n == cont_at) cont_a = 1'b1;
      if (early_drop && n == 1) done_a = 1'b0;
      tick();
      n++;
    end
    exp_n = (cont_at >= 0 && cont_at + 1 < HOLD_A) ? cont_at + 1 : HOLD_A;
    check("a_show_cycles", n, exp_n);
    if (done_a) begin
      repeat ($urandom_range(1, 3)) tick();
      done_a = 1'b0;
    end
    tick();
    check("a_disp_drop", 32'(disp_a), 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {done_a, rslt_a, cont_a, clr_a, done_b, rslt_b, cont_b, clr_b} = '0;
    {e_a, io_a, e_b, io_b} = '0;
    #3;
    ma = mdl_reset();
    mb = mdl_reset();
    cmp_both();
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Done glitch: one-cycle pulse, nothing captured.
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    repeat (3) tick();
    check("a_glitch_disp", 32'(disp_a), 0);

    // Reset asserted mid-SHOW.
    done_a = 1'b1;
    tick();
    rslt_a = 1'b1;
    tick();
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    cmp_both();
    check("a_reset_disp", 32'(disp_a), 0);
    done_a = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Directed handshakes.
    run_test(1'b1, -1, 1'b0, 1'b0);           // pass, full hold
    run_test(1'b0, -1, 1'b0, 1'b0);           // fail, full hold
    run_test(1'b1, 3, 1'b0, 1'b0);            // Continue ends hold early
    run_test(1'b1, -1, 1'b0, 1'b0);           // Continue still high: no new pulse
    cont_a = 1'b0;
    run_test(1'b1, -1, 1'b0, 1'b1);           // Done drops during SHOW
    run_test(1'b1, -1, 1'b0, 1'b0);           // fifth pass
    check("a_pass_saturated", 32'(pc_a), 3);
    check("a_fail_total", 32'(fc_a), 1);
    run_test(1'b1, -1, 1'b1, 1'b0);           // clear beats increment

    // Randomized handshakes.
    for (int i = 0; i < 30; i++) begin
      run_test(1'($urandom), ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 9)),
               ($urandom_range(0, 5) == 0), 1'($urandom));
      cont_a = 1'b0;
      clr_a  = ($urandom_range(0, 9) == 0);
      tick();
      clr_a  = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
